wb_matmul_engine: RTL
=====================

Name: wb_matmul_engine

Overview:
Wishbone-mapped signed integer matrix engine, the next generation of the accelerator top.
- Computes C = A×B for non-square operands (M×K times K×N), accumulates C += A×B, or adds element-wise C = A+B.
- Uses one sequential multiply-accumulate datapath over internal A/B/C storage.
- Sits on the SoC Wishbone slave bus and exposes status, busy and interrupt.

Parameters:
DATA_W, 16, signed element width of A and B
ACC_W, 32, signed width of C elements and accumulator (ACC_W <= 32, ACC_W >= 2*DATA_W)
IDX_BITS, 4, row/column index width; DIM_MAX = 2**IDX_BITS

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous active-high reset
wb_addr_i  in  32  byte-agnostic word address
wb_we_i  in  1  write enable
wb_data_i  in  32  write data
wb_data_o  out  32  read data
wb_stb  in  1  strobe
wb_ack  out  1  acknowledge
busy_o  out  1  computation in progress
irq_o  out  1  level interrupt, completion

Behaviour:
- Reset values: wb_ack=0, wb_data_o=0, busy_o=0, irq_o=0. OP, M, K and N registers are 0. Status bits are 0. FSM is IDLE. A/B/C storage is not cleared.
- Reset mid-operation aborts the computation. C contents are then undefined.

Address decode:
- Region = addr[2*IDX_BITS+1:2*IDX_BITS].
- Row = addr[2*IDX_BITS-1:IDX_BITS].
- Col = addr[IDX_BITS-1:0].
- Region 00 holds registers. Region 01 is A, 10 is B, 11 is C.

Register map (region 00, index = low bits):
- 0 OP: 1 MUL, 2 MAC, 3 ADD.
- 1 M, 2 K, 3 N.
- 4 GO (write any value).
- 5 STATUS (read-only): bit0 busy, bit1 done, bit2 err, bit3 ovf sticky.
- 6 IRQCLR (write clears irq_o and done).
- Other indices read 0; writes to them are ignored.

Handshake:
- wb_ack rises the cycle after wb_stb is first seen high and stays high exactly 1 cycle.
- No further ack is given until wb_stb has returned low.
- Read data is valid while wb_ack is high.
- A/B reads are sign-extended from DATA_W. A/B writes keep wb_data_i[DATA_W-1:0]. C reads and writes use [ACC_W-1:0], sign-extended on read.

While busy:
- Writes to OP, M, K, N, A, B, C and GO are acked and dropped.
- Reads of A, B and C return 0. STATUS reads normally.

FSM:
- IDLE: on GO go to CHECK.
- CHECK (1 cycle): error if any used dimension is 0 or > DIM_MAX, or OP is not 1..3.
  - On error: err=1, done=1, irq_o=1, back to IDLE, C untouched.
  - Otherwise: clear err and done, busy=1.
- INIT: load acc. MUL loads 0. MAC loads C[i][j]. ADD loads 0.
- MAC: MUL/MAC add A[i][k]*B[k][j] for k=0..K-1, one product per cycle. ADD does one cycle acc = A[i][j]+B[i][j].
- WRITE: C[i][j]=acc, advance j then i.
- After the last element go to DONE.
- DONE: busy=0, done=1, irq_o=1, back to IDLE.

Timing and dimensions:
- Latency from GO ack to done=1 is 1 + M*N*(K+2) cycles for MUL/MAC, and 1 + M*N*3 for ADD.
- Dimension rules: MUL/MAC use M, K, N. ADD uses M and N only.
- Arithmetic: products are 2*DATA_W signed, sign-extended to ACC_W+1 before the add.
- A GO issued while irq_o is high clears irq_o and done at CHECK.
- ovf is cleared only by reset or an IRQCLR write.

Optional Feature:
MATMUL_SAT_EN
- Defined: each accumulate saturates to the signed ACC_W range, and any clamp sets ovf.
- Undefined: accumulation wraps modulo 2**ACC_W, and STATUS bit3 always reads 0.

Test Plan:
1. MUL 2×2×2: A=[-3 -15; -6 7], B=[9 -15; -2 -5] -> C=[3 120; -68 55]. done=1, irq_o=1, latency 17 cycles.
2. MAC on the same data after scenario 1 -> C=[6 240; -136 110].
3. Non-square MUL M=2, K=3, N=1: A=[1 2 3; 4 5 6], B=[1;0;-1] -> C=[-2; -2], and C[0][1] is untouched.
4. GO with K=0 or M=17 (IDX_BITS=4), and separately OP=5 -> err=1, done=1, busy never high, C unchanged.
5. MATMUL_SAT_EN with K=3, all A and B elements 32767 -> C[0][0]=2147483647, ovf=1. Without the macro -> wrapped value -1073938429, bit3=0.
6. Write A[0][0]=99 while busy -> acked, ignored, A[0][0] unchanged. Assert wb_rst_i mid-MUL -> next cycle busy_o=0, irq_o=0, STATUS=0; a fresh run of scenario 1 passes.

Source files
------------

// File: rtl/wb_matmul_engine.sv
// Wishbone-mapped signed matrix engine: C = A*B, C += A*B or C = A+B over M x K x N operands.
// Define MATMUL_SAT_EN to make accumulation saturate and report overflow in STATUS bit3.
module wb_matmul_engine #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int IDX_BITS = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_addr_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  input  logic        wb_stb,
  output logic        wb_ack,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int DIM_MAX = 2 ** IDX_BITS;
  localparam int AW      = 2 * IDX_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_INIT,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

  logic signed [DATA_W-1:0] a_mem [DIM_MAX][DIM_MAX];
  logic signed [DATA_W-1:0] b_mem [DIM_MAX][DIM_MAX];
  logic signed [ACC_W-1:0]  c_mem [DIM_MAX][DIM_MAX];

  state_t state_q, state_d;
  logic ack_q, ack_d, served_q, served_d;
  logic [31:0] data_q, data_d;
  logic [31:0] op_q, op_d, m_q, m_d, k_q, k_d, n_q, n_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [IDX_BITS-1:0] i_q, i_d, j_q, j_d, kk_q, kk_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_new;

  logic [1:0]          region;
  logic [IDX_BITS-1:0] row, col;
  logic [AW-1:0]       reg_idx;
  logic                acc_en, wr_en, idle, go, clamp, cfg_bad;
  logic                a_we, b_we, c_bus_we, c_eng_we;
  logic [31:0]         rd_data;
  logic [IDX_BITS-1:0] m_last, n_last, k_last;
  logic signed [DATA_W-1:0]   a_ik, b_kj, a_ij, b_ij;
  logic signed [2*DATA_W-1:0] prod, addend;
  logic                unused_addr;

  assign region      = wb_addr_i[AW+1:AW];
  assign row         = wb_addr_i[AW-1:IDX_BITS];
  assign col         = wb_addr_i[IDX_BITS-1:0];
  assign reg_idx     = wb_addr_i[AW-1:0];
  assign unused_addr = ^wb_addr_i[31:AW+2];

  // One access per strobe: served stays set until the master drops wb_stb.
  assign acc_en = wb_stb && !served_q;
  assign wr_en  = acc_en && wb_we_i;
  assign idle   = (state_q == ST_IDLE);

  assign m_last = IDX_BITS'(m_q - 32'd1);
  assign n_last = IDX_BITS'(n_q - 32'd1);
  assign k_last = IDX_BITS'(k_q - 32'd1);

  assign a_ik = a_mem[i_q][kk_q];
  assign b_kj = b_mem[kk_q][j_q];
  assign a_ij = a_mem[i_q][j_q];
  assign b_ij = b_mem[i_q][j_q];

  function automatic logic dim_bad(input logic [31:0] d);
    return (d == 32'd0) || (d > 32'(DIM_MAX));
  endfunction

  always_comb begin
    cfg_bad = 1'b0;
    if (op_q < 32'd1 || op_q > 32'd3) cfg_bad = 1'b1;
    if (dim_bad(m_q) || dim_bad(n_q)) cfg_bad = 1'b1;
    if (op_q != 32'd3 && dim_bad(k_q)) cfg_bad = 1'b1;
  end

  // ADD reuses the accumulate step with a single element-wise sum instead of a product.
  always_comb begin
    prod   = a_ik * b_kj;
    addend = prod;
    if (op_q == 32'd3) addend = (2*DATA_W)'(a_ij) + (2*DATA_W)'(b_ij);
  end

`ifdef MATMUL_SAT_EN
  logic signed [ACC_W:0] sum_ext;
  always_comb begin
    sum_ext = (ACC_W+1)'(acc_q) + (ACC_W+1)'(addend);
    clamp   = (sum_ext[ACC_W] != sum_ext[ACC_W-1]);
    acc_new = sum_ext[ACC_W-1:0];
    if (clamp) acc_new = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  always_comb begin
    acc_new = acc_q + ACC_W'(addend);
    clamp   = 1'b0;
  end
`endif

  always_comb begin
    rd_data = '0;
    case (region)
      2'd0: begin
        case (reg_idx)
          AW'(0):  rd_data = op_q;
          AW'(1):  rd_data = m_q;
          AW'(2):  rd_data = k_q;
          AW'(3):  rd_data = n_q;
          AW'(5):  rd_data = {28'd0, ovf_q, err_q, done_q, busy_q};
          default: rd_data = '0;
        endcase
      end
      2'd1:    if (idle) rd_data = 32'(a_mem[row][col]);
      2'd2:    if (idle) rd_data = 32'(b_mem[row][col]);
      default: if (idle) rd_data = 32'(c_mem[row][col]);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = acc_en;
    served_d = wb_stb;
    data_d   = (acc_en && !wb_we_i) ? rd_data : '0;
    op_d     = op_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    irq_d    = irq_q;
    i_d      = i_q;
    j_d      = j_q;
    kk_d     = kk_q;
    acc_d    = acc_q;
    go       = 1'b0;
    a_we     = 1'b0;
    b_we     = 1'b0;
    c_bus_we = 1'b0;
    c_eng_we = 1'b0;

    if (wr_en) begin
      case (region)
        2'd0: begin
          case (reg_idx)
            AW'(0):  if (idle) op_d = wb_data_i;
            AW'(1):  if (idle) m_d = wb_data_i;
            AW'(2):  if (idle) k_d = wb_data_i;
            AW'(3):  if (idle) n_d = wb_data_i;
            AW'(4):  go = idle;
            AW'(6):  begin irq_d = 1'b0; done_d = 1'b0; ovf_d = 1'b0; end
            default: ;
          endcase
        end
        2'd1:    a_we = idle;
        2'd2:    b_we = idle;
        default: c_bus_we = idle;
      endcase
    end

    // Sequencer: per output element INIT, K accumulate cycles (one for ADD), then WRITE.
    case (state_q)
      ST_IDLE: if (go) state_d = ST_CHECK;
      ST_CHECK: begin
        if (cfg_bad) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          irq_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_d   = 1'b0;
          done_d  = 1'b0;
          irq_d   = 1'b0;
          busy_d  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        acc_d   = (op_q == 32'd2) ? c_mem[i_q][j_q] : '0;
        kk_d    = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_d = acc_new;
        if (clamp) ovf_d = 1'b1;
        if (op_q == 32'd3 || kk_q == k_last) state_d = ST_WRITE;
        else kk_d = kk_q + 1'b1;
      end
      ST_WRITE: begin
        c_eng_we = 1'b1;
        state_d  = ST_INIT;
        if (j_q == n_last) begin
          j_d = '0;
          if (i_q == m_last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      served_q <= 1'b0;
      data_q   <= '0;
      op_q     <= '0;
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      kk_q     <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      served_q <= served_d;
      data_q   <= data_d;
      op_q     <= op_d;
      m_q      <= m_d;
      k_q      <= k_d;
      n_q      <= n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kk_q     <= kk_d;
      acc_q    <= acc_d;
    end
  end

  // Operand storage is deliberately left out of reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (a_we) a_mem[row][col] <= wb_data_i[DATA_W-1:0];
      if (b_we) b_mem[row][col] <= wb_data_i[DATA_W-1:0];
      if (c_bus_we) c_mem[row][col] <= wb_data_i[ACC_W-1:0];
      else if (c_eng_we) c_mem[i_q][j_q] <= acc_q;
    end
  end

  assign wb_ack    = ack_q;
  assign wb_data_o = data_q;
  assign busy_o    = busy_q;
  assign irq_o     = irq_q;

endmodule
